rasterizer_scan_controller: RTL and testbench



---
 rtl/rasterizer_scan_controller_if.sv | 55 +++++
 rtl/rasterizer_scan_controller.sv | 160 ++++++++++++++++
 tb/tb_rasterizer_scan_controller.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rasterizer_scan_controller_if.sv
// Bundle between the scan controller, the triangle setup stage, the
// intersection detector and the fragment writer. master = controller side.
interface rasterizer_scan_controller_if #(
    parameter int HORIZ_RESOLUTION = 10,
    parameter int VERT_RESOLUTION  = 10
);
    localparam int XW = $clog2(HORIZ_RESOLUTION);
    localparam int YW = $clog2(VERT_RESOLUTION);

    logic                 i_tri_valid;
    logic                 o_tri_ready;
    logic [XW-1:0]        i_tri_p0_x, i_tri_p1_x, i_tri_p2_x;
    logic [YW-1:0]        i_tri_p0_y, i_tri_p1_y, i_tri_p2_y;
    logic signed [7:0]    i_tri_slack;

    logic                 o_det_load_triangle;
    logic [XW-1:0]        o_det_p0_x, o_det_p1_x, o_det_p2_x;
    logic [YW-1:0]        o_det_p0_y, o_det_p1_y, o_det_p2_y;
    logic signed [7:0]    o_det_slack;
    logic [2*XW-1:0]      o_det_point_x;
    logic [2*YW-1:0]      o_det_point_y;
    logic                 i_det_triangle_loaded;
    logic                 i_det_point_inside;

    logic                 o_frag_valid;
    logic                 i_frag_ready;
    logic [XW-1:0]        o_frag_x;
    logic [YW-1:0]        o_frag_y;

    logic                 o_busy;
    logic                 o_done;
    logic                 o_error;

    modport master (
        input  i_tri_valid, i_tri_p0_x, i_tri_p1_x, i_tri_p2_x,
               i_tri_p0_y, i_tri_p1_y, i_tri_p2_y, i_tri_slack,
               i_det_triangle_loaded, i_det_point_inside, i_frag_ready,
        output o_tri_ready, o_det_load_triangle,
               o_det_p0_x, o_det_p1_x, o_det_p2_x,
               o_det_p0_y, o_det_p1_y, o_det_p2_y, o_det_slack,
               o_det_point_x, o_det_point_y,
               o_frag_valid, o_frag_x, o_frag_y, o_busy, o_done, o_error
    );

    modport slave (
        output i_tri_valid, i_tri_p0_x, i_tri_p1_x, i_tri_p2_x,
               i_tri_p0_y, i_tri_p1_y, i_tri_p2_y, i_tri_slack,
               i_det_triangle_loaded, i_det_point_inside, i_frag_ready,
        input  o_tri_ready, o_det_load_triangle,
               o_det_p0_x, o_det_p1_x, o_det_p2_x,
               o_det_p0_y, o_det_p1_y, o_det_p2_y, o_det_slack,
               o_det_point_x, o_det_point_y,
               o_frag_valid, o_frag_x, o_frag_y, o_busy, o_done, o_error
    );
endinterface

// File: rtl/rasterizer_scan_controller.sv
// Per-triangle sequencer: loads the intersection detector, sweeps the clamped
// bounding box in row-major order and streams covered pixels as fragments.
module rasterizer_scan_controller #(
    parameter int HORIZ_RESOLUTION = 10,
    parameter int VERT_RESOLUTION  = 10,
    parameter int DETECT_LATENCY   = 2,
    parameter int LOAD_TIMEOUT     = 64
) (
    input  logic                          i_clk,
    input  logic                          i_srst_n,
    rasterizer_scan_controller_if.master  bus
);
    localparam int XW = $clog2(HORIZ_RESOLUTION);
    localparam int YW = $clog2(VERT_RESOLUTION);
    localparam int TW = $clog2(LOAD_TIMEOUT + 1);
    localparam int LW = $clog2(DETECT_LATENCY + 1);
    localparam logic [XW-1:0] X_LAST = XW'(HORIZ_RESOLUTION - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(VERT_RESOLUTION - 1);

    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] LOAD        = 3'd1;
    localparam logic [2:0] WAIT_LOADED = 3'd2;
    localparam logic [2:0] ISSUE       = 3'd3;
    localparam logic [2:0] WAIT_RESULT = 3'd4;
    localparam logic [2:0] EMIT        = 3'd5;
    localparam logic [2:0] DONE        = 3'd6;

    logic [2:0]        state;
    logic [XW-1:0]     p0_x, p1_x, p2_x, xmin, xmax, probe_x;
    logic [YW-1:0]     p0_y, p1_y, p2_y, ymin, ymax, probe_y;
    logic signed [7:0] slack;
    logic [TW-1:0]     to_cnt;
    logic [LW-1:0]     lat_cnt;
    logic              error;

    logic [XW-1:0]     in_xmin, in_xmax, next_x;
    logic [YW-1:0]     in_ymin, in_ymax, next_y;
    logic              last_probe;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        in_xmin = bus.i_tri_p0_x;
        if (bus.i_tri_p1_x < in_xmin) in_xmin = bus.i_tri_p1_x;
        if (bus.i_tri_p2_x < in_xmin) in_xmin = bus.i_tri_p2_x;
        in_xmax = bus.i_tri_p0_x;
        if (bus.i_tri_p1_x > in_xmax) in_xmax = bus.i_tri_p1_x;
        if (bus.i_tri_p2_x > in_xmax) in_xmax = bus.i_tri_p2_x;
        if (in_xmax > X_LAST)         in_xmax = X_LAST;

        in_ymin = bus.i_tri_p0_y;
        if (bus.i_tri_p1_y < in_ymin) in_ymin = bus.i_tri_p1_y;
        if (bus.i_tri_p2_y < in_ymin) in_ymin = bus.i_tri_p2_y;
        in_ymax = bus.i_tri_p0_y;
        if (bus.i_tri_p1_y > in_ymax) in_ymax = bus.i_tri_p1_y;
        if (bus.i_tri_p2_y > in_ymax) in_ymax = bus.i_tri_p2_y;
        if (in_ymax > Y_LAST)         in_ymax = Y_LAST;
    end

    // Row-major advance inside the bounding box; never used on the last probe.
    always_comb begin
        last_probe = (probe_x == xmax) && (probe_y == ymax);
        next_x     = probe_x + 1'b1;
        next_y     = probe_y;
        if (probe_x == xmax) begin
            next_x = xmin;
            next_y = probe_y + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_srst_n) begin
            state   <= IDLE;
            p0_x    <= '0; p1_x <= '0; p2_x <= '0;
            p0_y    <= '0; p1_y <= '0; p2_y <= '0;
            slack   <= '0;
            xmin    <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
            probe_x <= '0; probe_y <= '0;
            to_cnt  <= '0;
            lat_cnt <= '0;
            error   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_tri_valid) begin
                    p0_x  <= bus.i_tri_p0_x; p1_x <= bus.i_tri_p1_x; p2_x <= bus.i_tri_p2_x;
                    p0_y  <= bus.i_tri_p0_y; p1_y <= bus.i_tri_p1_y; p2_y <= bus.i_tri_p2_y;
                    slack <= bus.i_tri_slack;
                    xmin  <= in_xmin; xmax <= in_xmax;
                    ymin  <= in_ymin; ymax <= in_ymax;
                    error <= 1'b0;
                    state <= (in_xmin > X_LAST || in_ymin > Y_LAST) ? DONE : LOAD;
                end
                LOAD: begin
                    to_cnt <= '0;
                    state  <= WAIT_LOADED;
                end
                WAIT_LOADED: begin
                    if (bus.i_det_triangle_loaded) begin
                        probe_x <= xmin;
                        probe_y <= ymin;
                        state   <= ISSUE;
                    end else if (to_cnt == TW'(LOAD_TIMEOUT - 1)) begin
                        error <= 1'b1;
                        state <= DONE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                ISSUE: begin
                    lat_cnt <= LW'(1);
                    state   <= WAIT_RESULT;
                end
                WAIT_RESULT: begin
                    if (lat_cnt == LW'(DETECT_LATENCY)) begin
                        if (bus.i_det_point_inside) begin
                            state <= EMIT;
                        end else if (last_probe) begin
                            state <= DONE;
                        end else begin
                            probe_x <= next_x;
                            probe_y <= next_y;
                            state   <= ISSUE;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                EMIT: if (bus.i_frag_ready) begin
                    if (last_probe) begin
                        state <= DONE;
                    end else begin
                        probe_x <= next_x;
                        probe_y <= next_y;
                        state   <= ISSUE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_tri_ready         = (state == IDLE);
    assign bus.o_busy              = (state != IDLE);
    assign bus.o_done              = (state == DONE);
    assign bus.o_error             = error;
    assign bus.o_det_load_triangle = (state == LOAD);
    assign bus.o_det_p0_x          = p0_x;
    assign bus.o_det_p1_x          = p1_x;
    assign bus.o_det_p2_x          = p2_x;
    assign bus.o_det_p0_y          = p0_y;
    assign bus.o_det_p1_y          = p1_y;
    assign bus.o_det_p2_y          = p2_y;
    assign bus.o_det_slack         = slack;
    assign bus.o_det_point_x       = {{XW{1'b0}}, probe_x};
    assign bus.o_det_point_y       = {{YW{1'b0}}, probe_y};
    assign bus.o_frag_valid        = (state == EMIT);
    assign bus.o_frag_x            = probe_x;
    assign bus.o_frag_y            = probe_y;
endmodule

// File: tb/tb_rasterizer_scan_controller.sv
// Directed bench for rasterizer_scan_controller with a stub detector
// (loaded 3 cycles after load, 2-cycle result pipeline).
module tb_rasterizer_scan_controller;
    localparam int H  = 10;
    localparam int V  = 10;

    logic clk = 1'b0;
    logic srst_n;
    always #5 clk = ~clk;

    rasterizer_scan_controller_if #(.HORIZ_RESOLUTION(H), .VERT_RESOLUTION(V)) bus ();

    rasterizer_scan_controller #(
        .HORIZ_RESOLUTION(H), .VERT_RESOLUTION(V),
        .DETECT_LATENCY(2), .LOAD_TIMEOUT(64)
    ) dut (
        .i_clk(clk),
        .i_srst_n(srst_n),
        .bus(bus)
    );

    // ---------------- stub detector ----------------
    int   inside_mode = 0;      // 0: never, 1: x>=y, 2: always
    bit   never_load  = 1'b0;
    logic loaded      = 1'b0;
    int   ld_cnt      = 0;
    logic s1 = 1'b0, s2 = 1'b0;

    function automatic bit covers(int m, logic [7:0] px, logic [7:0] py);
        if (m == 0) return 1'b0;
        if (m == 1) return (px >= py);
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        if (bus.o_det_load_triangle) begin
            loaded <= 1'b0;
            ld_cnt <= 1;
        end else if (ld_cnt > 0) begin
            if (ld_cnt == 2 && !never_load) loaded <= 1'b1;
            ld_cnt <= (ld_cnt == 2) ? 0 : ld_cnt + 1;
        end
        s1 <= covers(inside_mode, bus.o_det_point_x, bus.o_det_point_y);
        s2 <= s1;
    end

    assign bus.i_det_triangle_loaded = loaded;
    assign bus.i_det_point_inside    = s2;

    // ---------------- monitor ----------------
    int          cyc = 0;
    int          n_load, n_probe, n_frag, n_done, n_order_err;
    int          load_cyc, probe_cyc0, done_cyc;
    logic [15:0] pt, prev_pt = '0, first_probe, last_probe;
    logic [7:0]  fr, first_frag, last_frag;
    logic [31:0] lat_cap;

    always @(negedge clk) begin
        cyc = cyc + 1;
        pt  = {bus.o_det_point_x, bus.o_det_point_y};
        if (srst_n) begin
            if (bus.o_det_load_triangle) begin
                n_load++;
                load_cyc = cyc;
                lat_cap  = {bus.o_det_p0_x, bus.o_det_p0_y, bus.o_det_p1_x, bus.o_det_p1_y,
                            bus.o_det_p2_x, bus.o_det_p2_y, bus.o_det_slack};
            end
            if (bus.o_busy && pt != prev_pt) begin
                if (n_probe == 0) begin
                    first_probe = pt;
                    probe_cyc0  = cyc;
                end
                last_probe = pt;
                n_probe++;
            end
            if (bus.o_frag_valid && bus.i_frag_ready) begin
                fr = {bus.o_frag_x, bus.o_frag_y};
                if (n_frag > 0 && {fr[3:0], fr[7:4]} <= {last_frag[3:0], last_frag[7:4]})
                    n_order_err++;
                if (n_frag == 0) first_frag = fr;
                last_frag = fr;
                n_frag++;
            end
            if (bus.o_done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
        prev_pt = pt;
    end

    // ---------------- checking helpers ----------------
    int total = 0, passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_mon();
        n_load = 0; n_probe = 0; n_frag = 0; n_done = 0; n_order_err = 0;
        load_cyc = 0; probe_cyc0 = 0; done_cyc = 0;
    endtask

    int acc_cyc;

    task automatic send_tri(input int x0, y0, x1, y1, x2, y2, input int sl);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.o_tri_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("tri_ready_timeout", 0, 1);
        bus.i_tri_p0_x = 4'(x0); bus.i_tri_p0_y = 4'(y0);
        bus.i_tri_p1_x = 4'(x1); bus.i_tri_p1_y = 4'(y1);
        bus.i_tri_p2_x = 4'(x2); bus.i_tri_p2_y = 4'(y2);
        bus.i_tri_slack = 8'(sl);
        bus.i_tri_valid = 1'b1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.i_tri_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (n_done > 0) begin ok = 1'b1; break; end
        end
        if (!ok) check("done_timeout", 0, 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_frag_valid(input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.o_frag_valid) begin ok = 1'b1; break; end
        end
        if (!ok) check("frag_valid_timeout", 0, 1);
    endtask

    function automatic logic [60:0] all_outs();
        return {bus.o_det_load_triangle, bus.o_det_p0_x, bus.o_det_p0_y, bus.o_det_p1_x,
                bus.o_det_p1_y, bus.o_det_p2_x, bus.o_det_p2_y, bus.o_det_slack,
                bus.o_det_point_x, bus.o_det_point_y, bus.o_frag_valid, bus.o_frag_x,
                bus.o_frag_y, bus.o_busy, bus.o_done, bus.o_error};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          x0, y0, x1, y1, x2, y2, slack, mode;
        int          loads, probes, frags;
        logic [15:0] fp, lp;        // {8'x, 8'y} first/last probe
        logic [7:0]  ff, lf;        // {4'x, 4'y} first/last fragment
        int          lat;           // first ISSUE -> DONE cycles, -1 = skip
        int          acc_max;       // accept -> DONE cycles upper bound, -1 = skip
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        int d;
        inside_mode = v.mode;
        never_load  = 1'b0;
        bus.i_frag_ready = 1'b1;
        clear_mon();
        send_tri(v.x0, v.y0, v.x1, v.y1, v.x2, v.y2, v.slack);
        wait_done(2000);
        check({v.name, "_loads"},  n_load,      v.loads);
        check({v.name, "_probes"}, n_probe,     v.probes);
        check({v.name, "_frags"},  n_frag,      v.frags);
        check({v.name, "_dones"},  n_done,      1);
        check({v.name, "_order"},  n_order_err, 0);
        if (v.probes > 0) begin
            check({v.name, "_first_probe"}, first_probe, v.fp);
            check({v.name, "_last_probe"},  last_probe,  v.lp);
        end
        if (v.frags > 0) begin
            check({v.name, "_first_frag"}, first_frag, v.ff);
            check({v.name, "_last_frag"},  last_frag,  v.lf);
        end
        if (v.loads > 0)
            check({v.name, "_latched"}, lat_cap,
                  {4'(v.x0), 4'(v.y0), 4'(v.x1), 4'(v.y1), 4'(v.x2), 4'(v.y2), 8'(v.slack)});
        if (v.lat >= 0)
            check({v.name, "_done_latency"}, done_cyc - probe_cyc0, v.lat);
        if (v.acc_max >= 0) begin
            d = done_cyc - acc_cyc;
            check({v.name, "_accept_to_done"}, (d >= 1 && d <= v.acc_max), 1);
        end
    endtask

    initial begin
        vecs[0] = '{"corner_pixel", 9,9, 9,9, 9,9, -3, 2, 1, 1, 1,
                    {8'd9,8'd9}, {8'd9,8'd9}, {4'd9,4'd9}, {4'd9,4'd9}, -1, -1};
        vecs[1] = '{"miss_all", 1,1, 8,1, 5,8, 5, 0, 1, 64, 0,
                    {8'd1,8'd1}, {8'd8,8'd8}, 8'h00, 8'h00, 192, -1};
        vecs[2] = '{"x_ge_y", 1,1, 8,1, 5,8, -7, 1, 1, 64, 36,
                    {8'd1,8'd1}, {8'd8,8'd8}, {4'd1,4'd1}, {4'd8,4'd8}, -1, -1};
        vecs[3] = '{"offscreen", 12,3, 14,5, 13,9, 1, 2, 0, 0, 0,
                    16'h0, 16'h0, 8'h00, 8'h00, -1, 2};
        vecs[4] = '{"clipped", 7,8, 15,2, 9,12, 127, 2, 1, 24, 24,
                    {8'd7,8'd2}, {8'd9,8'd9}, {4'd7,4'd2}, {4'd9,4'd9}, -1, -1};

        bus.i_tri_valid = 1'b0;
        bus.i_tri_p0_x = '0; bus.i_tri_p1_x = '0; bus.i_tri_p2_x = '0;
        bus.i_tri_p0_y = '0; bus.i_tri_p1_y = '0; bus.i_tri_p2_y = '0;
        bus.i_tri_slack = '0;
        bus.i_frag_ready = 1'b1;
        clear_mon();

        srst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs_zero", all_outs(), '0);
        check("reset_tri_ready", bus.o_tri_ready, 1);
        srst_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Backpressure: single covered pixel held for 10 cycles.
        begin
            int bad = 0;
            inside_mode = 2;
            bus.i_frag_ready = 1'b0;
            clear_mon();
            send_tri(4, 4, 4, 4, 4, 4, 0);
            wait_frag_valid(100);
            repeat (10) begin
                @(negedge clk);
                if (!(bus.o_frag_valid && bus.o_frag_x == 4'd4 && bus.o_frag_y == 4'd4)) bad++;
            end
            check("bp_hold_stable", bad, 0);
            check("bp_no_done_while_held", n_done, 0);
            @(posedge clk);
            #1;
            bus.i_frag_ready = 1'b1;
            wait_done(100);
            check("bp_frags", n_frag, 1);
            check("bp_frag_xy", first_frag, {4'd4, 4'd4});
            check("bp_dones", n_done, 1);
        end

        // Load timeout, then error cleared by the next accepted triangle.
        begin
            int d;
            inside_mode = 0;
            never_load  = 1'b1;
            clear_mon();
            send_tri(1, 1, 2, 2, 3, 3, 0);
            wait_done(300);
            d = done_cyc - load_cyc;
            check("timeout_latency_window", (d >= 64 && d <= 66), 1);
            check("timeout_no_probes", n_probe, 0);
            check("timeout_error_sticky", bus.o_error, 1);
            never_load = 1'b0;
            clear_mon();
            send_tri(12, 3, 14, 5, 13, 9, 0);
            check("error_cleared_on_accept", bus.o_error, 0);
            wait_done(50);
        end

        // Reset mid-scan while a fragment is pending, then a fresh scan.
        begin
            inside_mode = 2;
            bus.i_frag_ready = 1'b0;
            clear_mon();
            send_tri(1, 1, 3, 1, 2, 3, 9);
            wait_frag_valid(100);
            @(posedge clk);
            #1;
            srst_n = 1'b0;
            @(posedge clk);
            #1;
            check("midreset_outputs_zero", all_outs(), '0);
            check("midreset_tri_ready", bus.o_tri_ready, 1);
            srst_n = 1'b1;
            bus.i_frag_ready = 1'b1;
            clear_mon();
            send_tri(2, 5, 4, 5, 3, 6, 0);
            wait_done(500);
            check("post_reset_frags", n_frag, 6);
            check("post_reset_first_frag", first_frag, {4'd2, 4'd5});
            check("post_reset_last_frag", last_frag, {4'd4, 4'd6});
            check("post_reset_order", n_order_err, 0);
            check("post_reset_dones", n_done, 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
